// File: rtl/quad_step_decoder.sv
// Quadrature encoder front-end: synchronises qa/qb, filters glitches, decodes the Gray
// sequence into step/dir pulses and flags and counts illegal double-bit transitions.
module quad_step_decoder #(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned ERR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             qa,
  input  logic             qb,
  input  logic             clr_err,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [0:0] {S_INIT, S_RUN} state_t;

  localparam logic [4:0]       LP_FLEN = 5'(FILTER_LEN);
  localparam logic [ERR_W-1:0] LP_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync1, r_sync2;
  logic [1:0]       r_filt, w_filt_nxt;
  logic [1:0]       r_cand, w_cand_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [1:0]       r_init_cnt, w_init_nxt;
  logic             w_step_nxt, w_dir_nxt, w_err_nxt;
  logic [ERR_W-1:0] w_errcnt_nxt;
  logic [4:0]       w_n;
  logic [1:0]       w_delta;

  // Position of a {qb,qa} code in the 00->01->11->10 cycle.
  function automatic logic [1:0] gray_idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_filt     <= '0;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_init_cnt <= '0;
      step       <= 1'b0;
      dir        <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      r_sync1    <= {qb, qa};
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      r_filt     <= w_filt_nxt;
      r_cand     <= w_cand_nxt;
      r_cnt      <= w_cnt_nxt;
      r_init_cnt <= w_init_nxt;
      step       <= w_step_nxt;
      dir        <= w_dir_nxt;
      err        <= w_err_nxt;
      err_count  <= w_errcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_filt_nxt   = r_filt;
    w_cand_nxt   = r_cand;
    w_cnt_nxt    = r_cnt;
    w_init_nxt   = r_init_cnt;
    w_step_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_dir_nxt    = dir;
    w_n          = '0;
    w_delta      = '0;
    w_errcnt_nxt = err_count;

    case (r_state)
      S_INIT: begin
        // Third edge after release: the synchroniser now holds a real sample.
        if (r_init_cnt == 2'd2) begin
          w_filt_nxt  = r_sync2;
          w_cand_nxt  = r_sync2;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_init_nxt = r_init_cnt + 2'd1;
        end
      end
      S_RUN: begin
        if (r_sync2 == r_filt) begin
          w_cnt_nxt = '0;
        end else begin
          w_n        = (r_sync2 == r_cand) ? ({1'b0, r_cnt} + 5'd1) : 5'd1;
          w_cand_nxt = r_sync2;
          if (w_n >= LP_FLEN) begin
            w_filt_nxt = r_sync2;
            w_cnt_nxt  = '0;
            w_delta    = gray_idx(r_sync2) - gray_idx(r_filt);
            case (w_delta)
              2'd1:    begin w_step_nxt = 1'b1; w_dir_nxt = 1'b1; end
              2'd3:    begin w_step_nxt = 1'b1; w_dir_nxt = 1'b0; end
              default: w_err_nxt = 1'b1;
            endcase
          end else begin
            w_cnt_nxt = w_n[3:0];
          end
        end
      end
      default: w_state_nxt = S_INIT;
    endcase

    if (clr_err)
      w_errcnt_nxt = '0;
    else if (w_err_nxt && (err_count != '1))
      w_errcnt_nxt = err_count + LP_ONE;
  end

endmodule
